// File: rtl/ctrl_pkg.sv
// Shared control-bundle types, opType/ALU codes and FSM states
// for the pipelined control unit.
package ctrl_pkg;

  localparam int CTRL_ALU_W = 8;
  localparam int CTRL_RD_W  = 8;

  localparam logic [1:0] OPT_ALU_R = 2'b00;
  localparam logic [1:0] OPT_ALU_I = 2'b01;
  localparam logic [1:0] OPT_MEM   = 2'b10;
  localparam logic [1:0] OPT_BR    = 2'b11;

  localparam logic [CTRL_ALU_W-1:0] ALU_ADD = 8'd0;
  localparam logic [CTRL_ALU_W-1:0] ALU_SUB = 8'd1;

  typedef enum logic {
    RUN,
    MUL
  } ctrl_state_e;

  // Fields are sized for the widest supported opCode/register index;
  // stage outputs slice them back to the configured widths.
  typedef struct packed {
    logic                  valid;
    logic [CTRL_ALU_W-1:0] aluControl;
    logic                  immSrc;
    logic                  branchFlag;
    logic                  memWrite;
    logic                  memRead;
    logic                  memToReg;
    logic                  regWrite;
    logic                  isMul;
    logic [CTRL_RD_W-1:0]  rd;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational ID-stage decoder: opType/opCode to control bundle.
// An invalid ID slot decodes to an all-zero bubble.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int OPTYPE_W = 2,
  parameter int OPCODE_W = 4,
  parameter int REG_W    = 4,
  parameter logic [OPCODE_W-1:0] MUL_OPCODE = OPCODE_W'(5)
) (
  input  logic                valid,
  input  logic [OPTYPE_W-1:0] opType,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic [REG_W-1:0]    rd,
  output ctrl_bundle_t        bundle
);

  logic [1:0] opt;
  logic       is_r;
  logic       is_i;
  logic       is_m;
  logic       is_b;

  assign opt  = 2'(opType);
  assign is_r = (opt == OPT_ALU_R);
  assign is_i = (opt == OPT_ALU_I);
  assign is_m = (opt == OPT_MEM);
  assign is_b = (opt == OPT_BR);

  always_comb begin
    bundle = '0;
    if (valid) begin
      bundle.valid = 1'b1;
      bundle.rd    = CTRL_RD_W'(rd);
      unique case (1'b1)
        is_r: begin
          bundle.regWrite   = 1'b1;
          bundle.aluControl = CTRL_ALU_W'(opCode);
          bundle.isMul      = (opCode == MUL_OPCODE);
        end
        is_i: begin
          bundle.regWrite   = 1'b1;
          bundle.immSrc     = 1'b1;
          bundle.aluControl = CTRL_ALU_W'(opCode);
        end
        is_m: begin
          bundle.immSrc     = 1'b1;
          bundle.aluControl = ALU_ADD;
          if (opCode[0]) begin
            bundle.memWrite = 1'b1;
          end else begin
            bundle.memRead  = 1'b1;
            bundle.memToReg = 1'b1;
            bundle.regWrite = 1'b1;
          end
        end
        is_b: begin
          bundle.branchFlag = 1'b1;
          bundle.immSrc     = 1'b1;
          bundle.aluControl = ALU_SUB;
        end
        default: bundle = '0;
      endcase
    end
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, EX/MEM/WB control registers,
// load-use bubbles, branch flush and multi-cycle multiply stall.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPTYPE_W = 2,
  parameter int OPCODE_W = 4,
  parameter int REG_W    = 4,
  parameter logic [OPCODE_W-1:0] MUL_OPCODE = OPCODE_W'(5),
  parameter int MUL_LAT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPTYPE_W-1:0] opType,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rs2,
  input  logic [REG_W-1:0]    rd,
  input  logic                flush,
  output logic                id_ready,
  output logic                ex_valid,
  output logic [OPCODE_W-1:0] ex_aluControl,
  output logic                ex_immSrc,
  output logic                ex_branchFlag,
  output logic                ex_mulBusy,
  output logic                mem_valid,
  output logic                mem_memWrite,
  output logic                mem_memRead,
  output logic                wb_valid,
  output logic                wb_regWrite,
  output logic                wb_memToReg,
  output logic [REG_W-1:0]    wb_rd
);

  localparam int CNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  ctrl_bundle_t dec;
  ctrl_bundle_t ex_q;
  ctrl_bundle_t mem_q;
  ctrl_bundle_t wb_q;
  ctrl_bundle_t ex_d;
  ctrl_bundle_t mem_d;
  ctrl_bundle_t wb_d;

  ctrl_state_e    state;
  ctrl_state_e    state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic unused_bits;

  ctrl_decoder #(
    .OPTYPE_W   (OPTYPE_W),
    .OPCODE_W   (OPCODE_W),
    .REG_W      (REG_W),
    .MUL_OPCODE (MUL_OPCODE)
  ) u_dec (
    .valid  (id_valid),
    .opType (opType),
    .opCode (opCode),
    .rd     (rd),
    .bundle (dec)
  );

  // rs2 is compared even for ALU-imm: conservative, never misses a hazard
  assign rs1_hit  = (ex_q.rd == CTRL_RD_W'(rs1));
  assign rs2_hit  = (ex_q.rd == CTRL_RD_W'(rs2));
  assign load_use = id_valid && ex_q.valid && ex_q.memRead
                  && (rs1_hit || rs2_hit);

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ex_d     = ex_q;
    mem_d    = ex_q;
    wb_d     = mem_q;
    id_ready = 1'b1;
    unique case (state)
      MUL: begin
        id_ready = 1'b0;
        if (cnt == '0) begin
          state_d = RUN;
          ex_d    = '0;
        end else begin
          cnt_d = cnt - 1'b1;
          mem_d = '0;
        end
      end
      RUN: begin
        if (flush) begin
          ex_d = '0;
        end else if (load_use) begin
          ex_d     = '0;
          id_ready = 1'b0;
        end else begin
          ex_d = dec;
          if (dec.isMul) begin
            state_d = MUL;
            cnt_d   = CNT_INIT;
          end
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_aluControl = ex_q.aluControl[OPCODE_W-1:0];
  assign ex_immSrc     = ex_q.immSrc;
  assign ex_branchFlag = ex_q.branchFlag;
  assign ex_mulBusy    = (state == MUL);

  assign mem_valid     = mem_q.valid;
  assign mem_memWrite  = mem_q.memWrite;
  assign mem_memRead   = mem_q.memRead;

  assign wb_valid      = wb_q.valid;
  assign wb_regWrite   = wb_q.regWrite;
  assign wb_memToReg   = wb_q.memToReg;
  assign wb_rd         = wb_q.rd[REG_W-1:0];

  // Stage fields consumed by later stages only, or padding bits
  assign unused_bits = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios plus
// randomized traffic against a stage-level reference model.
module tb_pipe_control_unit;

  localparam int MUL_LAT = 3;
  localparam logic [3:0] MUL_OP = 4'b0101;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [1:0] opType = '0;
  logic [3:0] opCode = '0;
  logic [3:0] rs1 = '0;
  logic [3:0] rs2 = '0;
  logic [3:0] rd = '0;
  logic       flush = 1'b0;
  logic       id_ready;
  logic       ex_valid;
  logic [3:0] ex_aluControl;
  logic       ex_immSrc;
  logic       ex_branchFlag;
  logic       ex_mulBusy;
  logic       mem_valid;
  logic       mem_memWrite;
  logic       mem_memRead;
  logic       wb_valid;
  logic       wb_regWrite;
  logic       wb_memToReg;
  logic [3:0] wb_rd;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [18:0] obs;
  assign obs = {id_ready, ex_valid, ex_aluControl, ex_immSrc,
                ex_branchFlag, ex_mulBusy, mem_valid, mem_memWrite,
                mem_memRead, wb_valid, wb_regWrite, wb_memToReg, wb_rd};

  localparam logic [18:0] RESET_OBS = {1'b1, 18'b0};

  pipe_control_unit #(
    .OPTYPE_W   (2),
    .OPCODE_W   (4),
    .REG_W      (4),
    .MUL_OPCODE (MUL_OP),
    .MUL_LAT    (MUL_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .opType        (opType),
    .opCode        (opCode),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .flush         (flush),
    .id_ready      (id_ready),
    .ex_valid      (ex_valid),
    .ex_aluControl (ex_aluControl),
    .ex_immSrc     (ex_immSrc),
    .ex_branchFlag (ex_branchFlag),
    .ex_mulBusy    (ex_mulBusy),
    .mem_valid     (mem_valid),
    .mem_memWrite  (mem_memWrite),
    .mem_memRead   (mem_memRead),
    .wb_valid      (wb_valid),
    .wb_regWrite   (wb_regWrite),
    .wb_memToReg   (wb_memToReg),
    .wb_rd         (wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [3:0] alu;
    logic       imm;
    logic       br;
    logic       mw;
    logic       mr;
    logic       m2r;
    logic       rw;
    logic       mul;
    logic [3:0] rd;
  } ref_t;

  // Decode table written straight from the instruction-class rules
  function automatic ref_t ref_dec(logic v, logic [1:0] ot,
                                   logic [3:0] oc, logic [3:0] d);
    ref_t r;
    r = '0;
    if (v) begin
      r.v  = 1'b1;
      r.rd = d;
      if (ot == 2'd0) begin
        r.rw = 1'b1; r.alu = oc; r.mul = (oc == MUL_OP);
      end else if (ot == 2'd1) begin
        r.rw = 1'b1; r.imm = 1'b1; r.alu = oc;
      end else if (ot == 2'd2) begin
        r.imm = 1'b1; r.alu = 4'd0;
        if (oc[0]) r.mw = 1'b1;
        else begin r.mr = 1'b1; r.m2r = 1'b1; r.rw = 1'b1; end
      end else begin
        r.br = 1'b1; r.imm = 1'b1; r.alu = 4'd1;
      end
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] ot, logic [3:0] oc,
                       logic [3:0] a, logic [3:0] b, logic [3:0] d);
    id_valid = v; opType = ot; opCode = oc;
    rs1 = a; rs2 = b; rd = d;
  endtask

  task automatic idle(int n);
    id_valid = 1'b0;
    flush    = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want %b", obs, RESET_OBS);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b", obs, RESET_OBS);
    end
  endtask

  task automatic test_sequence();
    drive(1, 2'b00, 4'b0010, 4'd7, 4'd8, 4'd1);
    cyc();
    n_cmp++;
    if ({ex_valid, ex_aluControl, ex_immSrc, ex_branchFlag} !== 7'b1_0010_00) begin
      n_fail++;
      $display("FAIL seq_alu_ex: got v=%b alu=%h imm=%b br=%b want 1 2 0 0",
               ex_valid, ex_aluControl, ex_immSrc, ex_branchFlag);
    end
    drive(1, 2'b10, 4'b0001, 4'd9, 4'd10, 4'd2);
    cyc();
    n_cmp++;
    if ({ex_valid, ex_aluControl, ex_immSrc, mem_valid, mem_memWrite,
         mem_memRead} !== 9'b1_0000_1_100) begin
      n_fail++;
      $display("FAIL seq_store_ex: got exv=%b alu=%h imm=%b memv=%b mw=%b mr=%b want 1 0 1 1 0 0",
               ex_valid, ex_aluControl, ex_immSrc, mem_valid, mem_memWrite, mem_memRead);
    end
    drive(1, 2'b11, 4'b0110, 4'd9, 4'd10, 4'd0);
    cyc();
    n_cmp++;
    if ({ex_branchFlag, ex_aluControl, ex_immSrc, mem_memWrite,
         wb_valid, wb_regWrite, wb_rd} !== 14'b1_0001_1_1_1_1_0001) begin
      n_fail++;
      $display("FAIL seq_branch_ex: got br=%b alu=%h imm=%b mw=%b wbv=%b rw=%b rd=%h want 1 1 1 1 1 1 1",
               ex_branchFlag, ex_aluControl, ex_immSrc, mem_memWrite, wb_valid, wb_regWrite, wb_rd);
    end
    id_valid = 1'b0;
    cyc();
    n_cmp++;
    if ({mem_valid, mem_memWrite, wb_valid, wb_regWrite} !== 4'b1010) begin
      n_fail++;
      $display("FAIL seq_store_wb: got memv=%b mw=%b wbv=%b rw=%b want 1 0 1 0",
               mem_valid, mem_memWrite, wb_valid, wb_regWrite);
    end
    cyc();
    n_cmp++;
    if ({ex_valid, wb_valid, wb_regWrite} !== 3'b010) begin
      n_fail++;
      $display("FAIL seq_branch_wb: got exv=%b wbv=%b rw=%b want 0 1 0",
               ex_valid, wb_valid, wb_regWrite);
    end
  endtask

  task automatic test_load_use();
    idle(4);
    drive(1, 2'b10, 4'b0000, 4'd0, 4'd0, 4'd3);
    cyc();
    drive(1, 2'b00, 4'b0010, 4'd3, 4'd4, 4'd5);
    #1;
    n_cmp++;
    if ({ex_valid, id_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL lu_stall: got exv=%b ready=%b want 1 0", ex_valid, id_ready);
    end
    cyc();
    n_cmp++;
    if ({ex_valid, mem_memRead, id_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL lu_bubble: got exv=%b mr=%b ready=%b want 0 1 1",
               ex_valid, mem_memRead, id_ready);
    end
    cyc();
    id_valid = 1'b0;
    n_cmp++;
    if ({ex_valid, ex_aluControl, wb_memToReg, wb_rd} !== 10'b1_0010_1_0011) begin
      n_fail++;
      $display("FAIL lu_alu_ex: got exv=%b alu=%h m2r=%b rd=%h want 1 2 1 3",
               ex_valid, ex_aluControl, wb_memToReg, wb_rd);
    end
  endtask

  task automatic test_mul();
    int busy;
    int stall;
    int bub;
    int k;
    idle(4);
    drive(1, 2'b00, MUL_OP, 4'd1, 4'd2, 4'd6);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_accept: got ready=%b want 1", id_ready);
    end
    cyc();
    drive(1, 2'b00, 4'b0011, 4'd1, 4'd2, 4'd7);
    #1;
    busy = 0; stall = 0; bub = 0; k = 0;
    while (ex_mulBusy === 1'b1 && k < 20) begin
      busy++;
      if (id_ready === 1'b0) stall++;
      if (k > 0 && mem_valid === 1'b0) bub++;
      k++;
      cyc();
    end
    n_cmp++;
    if (busy != MUL_LAT || stall != MUL_LAT) begin
      n_fail++;
      $display("FAIL mul_busy_cycles: got busy=%0d stall=%0d want %0d %0d",
               busy, stall, MUL_LAT, MUL_LAT);
    end
    n_cmp++;
    if (bub != MUL_LAT - 1) begin
      n_fail++;
      $display("FAIL mul_mem_bubbles: got %0d want %0d", bub, MUL_LAT - 1);
    end
    n_cmp++;
    if ({mem_valid, mem_memWrite, ex_valid, id_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL mul_to_mem: got memv=%b mw=%b exv=%b ready=%b want 1 0 0 1",
               mem_valid, mem_memWrite, ex_valid, id_ready);
    end
    cyc();
    id_valid = 1'b0;
    n_cmp++;
    if ({wb_valid, wb_regWrite, wb_rd, ex_valid, ex_aluControl} !== 11'b1_1_0110_1_0011) begin
      n_fail++;
      $display("FAIL mul_wb: got wbv=%b rw=%b rd=%h exv=%b alu=%h want 1 1 6 1 3",
               wb_valid, wb_regWrite, wb_rd, ex_valid, ex_aluControl);
    end
  endtask

  task automatic test_flush();
    idle(4);
    drive(1, 2'b00, 4'b0010, 4'd1, 4'd2, 4'd4);
    cyc();
    drive(1, 2'b00, 4'b0010, 4'd1, 4'd2, 4'd8);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: got %b want 1", id_ready);
    end
    cyc();
    flush = 1'b0;
    id_valid = 1'b0;
    n_cmp++;
    if ({ex_valid, mem_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_ex_bubble: got exv=%b memv=%b want 0 1", ex_valid, mem_valid);
    end
    cyc();
    cyc();
    n_cmp++;
    if ({wb_valid, wb_regWrite} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_no_wb: got wbv=%b rw=%b rd=%h want 0 0",
               wb_valid, wb_regWrite, wb_rd);
    end
  endtask

  task automatic test_flush_load_use();
    idle(4);
    drive(1, 2'b10, 4'b0000, 4'd0, 4'd0, 4'd3);
    cyc();
    drive(1, 2'b00, 4'b0010, 4'd3, 4'd3, 4'd9);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_lu_ready: got %b want 1", id_ready);
    end
    cyc();
    flush = 1'b0;
    id_valid = 1'b0;
    n_cmp++;
    if ({ex_valid, mem_memRead, id_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL flush_lu_advance: got exv=%b mr=%b ready=%b want 0 1 1",
               ex_valid, mem_memRead, id_ready);
    end
  endtask

  task automatic test_async_reset();
    idle(4);
    drive(1, 2'b00, MUL_OP, 4'd1, 4'd2, 4'd5);
    cyc();
    id_valid = 1'b0;
    n_cmp++;
    if (ex_mulBusy !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_mul_start: got busy=%b want 1", ex_mulBusy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs !== RESET_OBS) begin
      n_fail++;
      $display("FAIL arst_clear: got %b want %b", obs, RESET_OBS);
    end
    #1;
    rst = 1'b0;
    cyc();
    n_cmp++;
    if ({ex_mulBusy, ex_valid, id_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL arst_run: got busy=%b exv=%b ready=%b want 0 0 1",
               ex_mulBusy, ex_valid, id_ready);
    end
  endtask

  task automatic test_random();
    ref_t m_ex;
    ref_t m_mem;
    ref_t m_wb;
    ref_t d;
    int busy_left;
    logic hold;
    logic hz;
    logic exp_ready;
    logic [18:0] exp;
    idle(2);
    m_ex = '0; m_mem = '0; m_wb = '0;
    busy_left = 0;
    hold = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!hold) begin
        id_valid = ($urandom_range(0, 3) != 0);
        opType   = 2'($urandom_range(0, 3));
        opCode   = 4'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          opType = 2'b00;
          opCode = MUL_OP;
        end
        rs1 = 4'($urandom_range(0, 3));
        rs2 = 4'($urandom_range(0, 3));
        rd  = 4'($urandom_range(0, 3));
      end
      flush = ($urandom_range(0, 7) == 0);
      hz = m_ex.v && m_ex.mr && id_valid && (m_ex.rd == rs1 || m_ex.rd == rs2);
      exp_ready = (busy_left == 0) && (flush || !hz);
      exp = {exp_ready, m_ex.v, m_ex.alu, m_ex.imm, m_ex.br,
             busy_left != 0, m_mem.v, m_mem.mw, m_mem.mr,
             m_wb.v, m_wb.rw, m_wb.m2r, m_wb.rd};
      @(negedge clk);
      n_cmp++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rand_cycle%0d: got %b want %b", i, obs, exp);
      end
      @(posedge clk);
      m_wb = m_mem;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_mem = m_ex;
          m_ex  = '0;
        end else begin
          m_mem = '0;
        end
      end else begin
        m_mem = m_ex;
        if (flush || hz) begin
          m_ex = '0;
        end else begin
          d = ref_dec(id_valid, opType, opCode, rd);
          m_ex = d;
          if (d.mul) busy_left = MUL_LAT;
        end
      end
      hold = !exp_ready;
      #1;
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_load_use();
    test_mul();
    test_flush();
    test_flush_load_use();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
